// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared FSM encodings and beat/counter sizing helpers for the
//                shift_reg_xfer serializer/deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_latch = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_SHIFT = c_st_shift,
        ST_LATCH = c_st_latch
    } state_t;

    // Beats per frame: each lane carries WIDTH/LANES bits.
    function automatic int calc_beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // A single-beat frame still needs a one-bit counter.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_lane.sv
`default_nettype none
// ============================================================================
//  Module      : shift_lane
//  Description : One serial lane: loads a BEATS-bit slice, presents one bit
//                per beat on a registered output and captures the return bit
//                into the same slice position.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_lane
    import shift_reg_pkg::*;
#(
    parameter int BEATS     = 8,
    parameter int MSB_FIRST = 1,
    localparam int c_cw     = calc_cnt_w(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_last,
    input  logic [c_cw-1:0]  i_beat,
    input  logic [BEATS-1:0] i_par,
    input  logic             i_s_in,
    output logic             o_s_out,
    output logic [BEATS-1:0] o_cap_next
);

    localparam logic [c_cw-1:0] c_pos_first = (MSB_FIRST != 0) ? c_cw'(BEATS - 1) : '0;

    logic [BEATS-1:0] r_data;
    logic [BEATS-1:0] r_cap;
    logic [BEATS-1:0] w_cap_nxt;
    logic             r_s_out;
    logic [c_cw-1:0]  w_beat_nxt;
    logic [c_cw-1:0]  w_pos_cur;
    logic [c_cw-1:0]  w_pos_nxt;

    function automatic logic [c_cw-1:0] slice_pos(input logic [c_cw-1:0] beat);
        if (MSB_FIRST != 0)
            return c_cw'(BEATS - 1) - beat;
        return beat;
    endfunction

    // The next-beat index is clamped on the last beat so it never leaves the slice.
    always_comb begin
        w_beat_nxt           = i_last ? i_beat : i_beat + c_cw'(1);
        w_pos_cur            = slice_pos(i_beat);
        w_pos_nxt            = slice_pos(w_beat_nxt);
        w_cap_nxt            = r_cap;
        w_cap_nxt[w_pos_cur] = i_s_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_cap   <= '0;
            r_s_out <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_par;
            r_cap   <= '0;
            r_s_out <= i_par[c_pos_first];
        end else if (i_shift) begin
            r_cap   <= w_cap_nxt;
            r_s_out <= i_last ? 1'b0 : r_data[w_pos_nxt];
        end
    end

    assign o_s_out    = r_s_out;
    assign o_cap_next = w_cap_nxt;

endmodule
`default_nettype wire

// File: rtl/shift_reg_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_xfer
//  Description : Parallel-to-serial transfer over LANES lanes with loopback
//                capture, a one-cycle latch strobe and a captured-word output.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_xfer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             serclk,
    input  logic             reset,
    input  logic             par_valid,
    output logic             par_ready,
    input  logic [WIDTH-1:0] par_data_in,
    input  logic [LANES-1:0] s_in,
    output logic [LANES-1:0] s_out,
    output logic             s_load,
    output logic [WIDTH-1:0] par_data_out,
    output logic             par_out_valid,
    output logic             busy
);

    localparam int c_beats                = calc_beats(WIDTH, LANES);
    localparam int c_cw                   = calc_cnt_w(c_beats);
    localparam logic [c_cw-1:0] c_last_bt = c_cw'(c_beats - 1);

    if (WIDTH % LANES != 0) begin : g_cfg_check
        $error("shift_reg_xfer: WIDTH must be a multiple of LANES");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_cw-1:0]  r_beat;
    logic [c_cw-1:0]  w_beat_nxt;
    logic [WIDTH-1:0] r_par_out;
    logic [WIDTH-1:0] w_cap_nxt;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;

    assign w_shift  = (r_state == ST_SHIFT);
    assign w_last   = (r_beat == c_last_bt);
    assign w_accept = par_valid && par_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        par_ready     = 1'b0;
        s_load        = 1'b0;
        par_out_valid = 1'b0;
        busy          = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                par_ready = !reset;
                if (par_valid && !reset) begin
                    w_state_nxt = ST_SHIFT;
                    w_beat_nxt  = '0;
                end
            end
            ST_SHIFT: begin
                // Counter stops at the last beat; the frame leaves SHIFT instead of wrapping.
                if (w_last) begin
                    w_state_nxt = ST_LATCH;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt  = r_beat + c_cw'(1);
                end
            end
            ST_LATCH: begin
                s_load        = 1'b1;
                par_out_valid = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The captured word includes the bit sampled on the edge that ends the last beat.
    always_ff @(posedge serclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_par_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_shift && w_last)
                r_par_out <= w_cap_nxt;
        end
    end

    assign par_data_out = r_par_out;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        shift_lane #(
            .BEATS     (c_beats),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk        (serclk),
            .rst        (reset),
            .i_load     (w_accept),
            .i_shift    (w_shift),
            .i_last     (w_last),
            .i_beat     (r_beat),
            .i_par      (par_data_in[l*c_beats +: c_beats]),
            .i_s_in     (s_in[l]),
            .o_s_out    (s_out[l]),
            .o_cap_next (w_cap_nxt[l*c_beats +: c_beats])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_xfer
//  Description : Directed bench for shift_reg_xfer in three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_xfer;

    typedef struct {
        int         sel;      // 0: MSB 1 lane, 1: LSB 1 lane, 2: MSB 2 lanes
        logic [1:0] mode;     // 0: loopback, 1: s_in ones, 2: s_in zeros
        logic [7:0] word;
        logic [7:0] exp_seq;  // s_out beats packed first-beat-high
        logic [7:0] exp_pdo;
    } vec_t;

    logic       clk, rst;
    logic [7:0] pdin;
    logic [2:0] pvalid;
    int         sel;
    logic [1:0] sin_mode;
    int         checks = 0;
    int         errors = 0;

    logic       a_ready, a_load, a_pov, a_busy;
    logic [0:0] a_sout, a_sin;
    logic [7:0] a_pdo;
    logic       b_ready, b_load, b_pov, b_busy;
    logic [0:0] b_sout, b_sin;
    logic [7:0] b_pdo;
    logic       c_ready, c_load, c_pov, c_busy;
    logic [1:0] c_sout, c_sin;
    logic [7:0] c_pdo;

    logic       cur_ready, cur_load, cur_pov, cur_busy;
    logic [1:0] cur_sout;
    logic [7:0] cur_pdo;

    assign a_sin = (sin_mode == 2'd0) ? a_sout : ((sin_mode == 2'd1) ? 1'b1 : 1'b0);
    assign b_sin = (sin_mode == 2'd0) ? b_sout : ((sin_mode == 2'd1) ? 1'b1 : 1'b0);
    assign c_sin = (sin_mode == 2'd0) ? c_sout : ((sin_mode == 2'd1) ? 2'b11 : 2'b00);

    shift_reg_xfer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) u_dut_a (
        .serclk(clk), .reset(rst), .par_valid(pvalid[0]), .par_ready(a_ready),
        .par_data_in(pdin), .s_in(a_sin), .s_out(a_sout), .s_load(a_load),
        .par_data_out(a_pdo), .par_out_valid(a_pov), .busy(a_busy));

    shift_reg_xfer #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_dut_b (
        .serclk(clk), .reset(rst), .par_valid(pvalid[1]), .par_ready(b_ready),
        .par_data_in(pdin), .s_in(b_sin), .s_out(b_sout), .s_load(b_load),
        .par_data_out(b_pdo), .par_out_valid(b_pov), .busy(b_busy));

    shift_reg_xfer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_dut_c (
        .serclk(clk), .reset(rst), .par_valid(pvalid[2]), .par_ready(c_ready),
        .par_data_in(pdin), .s_in(c_sin), .s_out(c_sout), .s_load(c_load),
        .par_data_out(c_pdo), .par_out_valid(c_pov), .busy(c_busy));

    always_comb begin
        cur_ready = a_ready;
        cur_load  = a_load;
        cur_pov   = a_pov;
        cur_busy  = a_busy;
        cur_sout  = {1'b0, a_sout};
        cur_pdo   = a_pdo;
        if (sel == 1) begin
            cur_ready = b_ready;
            cur_load  = b_load;
            cur_pov   = b_pov;
            cur_busy  = b_busy;
            cur_sout  = {1'b0, b_sout};
            cur_pdo   = b_pdo;
        end else if (sel == 2) begin
            cur_ready = c_ready;
            cur_load  = c_load;
            cur_pov   = c_pov;
            cur_busy  = c_busy;
            cur_sout  = c_sout;
            cur_pdo   = c_pdo;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts at a falling edge with the selected DUT idle; ends at a falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        int         lanes;
        int         beats;
        int         bad;
        logic [7:0] seq;
        lanes    = (v.sel == 2) ? 2 : 1;
        beats    = 8 / lanes;
        sel      = v.sel;
        sin_mode = v.mode;
        pdin     = v.word;
        #1;
        check($sformatf("v%0d ready_before", idx), 32'(cur_ready), 32'd1);
        pvalid[v.sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pvalid[v.sel] = 1'b0;
        seq = '0;
        bad = 0;
        for (int c = 0; c < beats; c++) begin
            if (c > 0) @(negedge clk);
            seq = (seq << lanes) | 8'(cur_sout);
            if (cur_load || cur_pov || !cur_busy || cur_ready) bad++;
        end
        check($sformatf("v%0d sout_seq", idx), 32'(seq), 32'(v.exp_seq));
        check($sformatf("v%0d ctrl_during_shift", idx), 32'(bad), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d latch_strobes", idx), 32'({cur_load, cur_pov, cur_busy}), 32'b111);
        check($sformatf("v%0d pdo_latch", idx), 32'(cur_pdo), 32'(v.exp_pdo));
        check($sformatf("v%0d sout_latch", idx), 32'(cur_sout), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), 32'({cur_ready, cur_busy, cur_load, cur_pov}), 32'b1000);
        check($sformatf("v%0d pdo_hold", idx), 32'(cur_pdo), 32'(v.exp_pdo));
    endtask

    vec_t vecs[9];

    initial begin
        int         bad;
        int         n_acc;
        int         n_lat;
        int         cyc;
        int         acc[2];
        logic [7:0] lat[2];

        vecs[0] = '{0, 2'd0, 8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{0, 2'd2, 8'hFF, 8'hFF, 8'h00};
        vecs[2] = '{1, 2'd0, 8'hA5, 8'hA5, 8'hA5};
        vecs[3] = '{2, 2'd0, 8'hC3, 8'hA5, 8'hC3};
        vecs[4] = '{1, 2'd0, 8'h1E, 8'h78, 8'h1E};
        vecs[5] = '{2, 2'd0, 8'h96, 8'h96, 8'h96};
        vecs[6] = '{1, 2'd2, 8'hF0, 8'h0F, 8'h00};
        vecs[7] = '{2, 2'd1, 8'h5A, 8'h66, 8'hFF};
        vecs[8] = '{0, 2'd1, 8'h3C, 8'h3C, 8'hFF};

        rst      = 1'b1;
        pvalid   = '0;
        pdin     = '0;
        sel      = 0;
        sin_mode = 2'd0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'({a_ready, b_ready, c_ready}), 32'd0);
        check("reset_outputs", 32'({a_sout, b_sout, c_sout, a_load, a_pov, a_busy, c_load, c_pov, c_busy}), 32'd0);
        check("reset_pdo", 32'({a_pdo, b_pdo, c_pdo}), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_release", 32'({a_ready, b_ready, c_ready}), 32'b111);
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the middle of beat 3 of an all-ones frame.
        sel      = 0;
        sin_mode = 2'd1;
        pdin     = 8'hFF;
        pvalid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pvalid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_beat3_sout", 32'({cur_busy, cur_sout}), 32'b101);
        rst = 1'b1;
        #1;
        check("midreset_sout_now", 32'(cur_sout), 32'd0);
        check("midreset_ctrl_now", 32'({cur_busy, cur_load, cur_pov, cur_ready}), 32'd0);
        check("midreset_pdo", 32'(cur_pdo), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cur_load || cur_pov || cur_busy || (cur_sout != 2'd0)) bad++;
        end
        check("midreset_no_pulse", 32'(bad), 32'd0);
        rst = 1'b0;
        #1;
        check("midreset_ready_release", 32'(cur_ready), 32'd1);
        run_vec('{0, 2'd0, 8'h5A, 8'h5A, 8'h5A}, 9);

        // par_valid held high across two words.
        sel      = 0;
        sin_mode = 2'd0;
        pdin     = 8'h81;
        pvalid[0] = 1'b1;
        n_acc = 0;
        n_lat = 0;
        cyc   = 0;
        acc   = '{-1, -1};
        lat   = '{8'h00, 8'h00};
        while (cyc < 40 && n_lat < 2) begin
            if (n_acc == 1) pdin = 8'h7E;
            if (n_acc >= 2) pvalid[0] = 1'b0;
            #1;
            if (cur_load) begin
                if (n_lat < 2) lat[n_lat] = cur_pdo;
                n_lat++;
            end
            if (pvalid[0] && cur_ready) begin
                if (n_acc < 2) acc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        pvalid[0] = 1'b0;
        check("b2b_accept_count", 32'(n_acc), 32'd2);
        check("b2b_accept_spacing", 32'(acc[1] - acc[0]), 32'd10);
        check("b2b_word0", 32'(lat[0]), 32'h81);
        check("b2b_word1", 32'(lat[1]), 32'h7E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
